rf_wless_packet_scheduler: RTL and testbench
============================================

// Module: rf_wless_packet_scheduler
// PURPOSE
//  Parametrised successor to the fixed 64-byte wireless-TX path. Buffers bytes from the MCU UART (com_uart RX),
//  cuts them into air packets (threshold or idle timeout), streams each packet to the node UART (com_uart TX).
//  Adds fixed-address mode: 3-byte header (addr_hi, addr_lo, chan) prepended to every packet; drives AUX busy.
//  Sits between the MCU-side com_uart and the node-side com_uart, inside the transceiver top.
// PARAMETERS
//  DATA_WIDTH        8     byte width
//  FIFO_DEPTH        64    payload buffer entries; power of 2, >=4
//  START_THRESHOLD   58    fill level that triggers a send; 1..FIFO_DEPTH
//  MAX_PACKET        58    max payload bytes per packet; 1..FIFO_DEPTH
//  IDLE_TIMEOUT      5000  cycles without a new MCU byte before a partial buffer is flushed
//  GAP_CYCLES        16    idle cycles forced between packets
// PORTS
//  internal_clk        in   1            clock
//  rst_n               in   1            asynchronous reset, active low
//  enable              in   1            module in WTRANS/IDLE state; 0 = no new accepts
//  fixed_mode          in   1            1 = fixed-address framing; sampled on IDLE->COLLECT
//  rx_flag_mcu         in   1            MCU UART has a byte available
//  data_from_uart_mcu  in   DATA_WIDTH   byte, valid while rx_flag_mcu=1
//  rx_use_mcu          out  1            1-cycle pulse: byte consumed
//  tx_flag_node        in   1            node UART TX cannot accept (full)
//  tx_use_node         out  1            1-cycle pulse: data_to_uart_node valid, push
//  data_to_uart_node   out  DATA_WIDTH   byte to node UART
//  fill_level          out  log2(D)+1    current payload count
//  overflow            out  1            sticky: byte dropped while full
//  overflow_clr        in   1            synchronous clear of overflow
//  packet_start        out  1            1-cycle pulse on first byte of each packet
//  aux                 out  1            1 only when IDLE and buffer empty
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except aux=1; FIFO empty; header regs 0; timers 0.
//  Accept: rx_flag_mcu & enable & (rx_use_mcu==0 last cycle) -> rx_use_mcu=1, byte captured same edge.
//   Max one accept every 2 cycles (com_uart flag updates one cycle after use).
//  Fixed mode: first 3 accepted bytes after IDLE go to addr_hi, addr_lo, chan (not FIFO); payload follows.
//  Full: byte still consumed (rx_use_mcu pulses), dropped, overflow<=1; overflow_clr wins only if no drop same cycle.
//  States: IDLE, COLLECT, HDR, SEND, GAP.
//   IDLE: first accept -> COLLECT; latch fixed_mode.
//   COLLECT: idle timer resets on each accept, +1 otherwise (saturating).
//    -> HDR if fixed else SEND, when fill>=START_THRESHOLD or (fill>0 & timer==IDLE_TIMEOUT).
//    On entry latch pkt_len = min(fill, MAX_PACKET).
//   HDR: emit addr_hi, addr_lo, chan; then SEND.
//   SEND: pop pkt_len bytes; then GAP.
//   GAP: GAP_CYCLES wait; then COLLECT if fill>0 (timer 0), else IDLE (header invalidated).
//  Emission: tx_use_node pulses only when tx_flag_node==0; max one push per 2 cycles; data registered with pulse.
//   packet_start coincides with first pushed byte of the packet (header byte in fixed mode).
//  MCU accepts continue during HDR/SEND/GAP; simultaneous push and pop keeps fill constant.
//  Pointers wrap modulo FIFO_DEPTH; fill_level reaches FIFO_DEPTH exactly when full.
//  enable=0 mid-packet: current packet completes, no new accepts; then holds in COLLECT/IDLE.
//  rst_n low at any time: immediate return to reset values; partial packet discarded.
//  aux goes 0 in the cycle after the first accept; returns to 1 on GAP->IDLE.
// STRUCTURE
//  rf_transceiver_defs.vh: state encodings (localparam), DATA_WIDTH default, header length (3).
//  Sub-module rf_sync_fifo (DATA_WIDTH, FIFO_DEPTH): wr/rd strobes, dout, count, full/empty.
//  Top holds FSM, idle timer, header regs, pkt_len counter, handshake pulse logic.
// TESTING
//  1) Transparent mode, 58 bytes 0x00..0x39 -> one packet, 58 pushes in order, packet_start once, aux back to 1.
//  2) 5 bytes, then silence -> flush after IDLE_TIMEOUT cycles (+/-1); 5 pushes; state IDLE.
//  3) Fixed mode, bytes 0x12,0x34,0x07 then 100 payload bytes -> packets of 58 and 42, each preceded by 12 34 07.
//  4) tx_flag_node held 1 for 200 cycles mid-SEND -> no pushes while high; order preserved, no loss.
//  5) Fill to 64 with tx_flag_node=1, send 3 more -> 3 rx_use pulses, overflow=1, fill_level=64; overflow_clr -> 0.
//  6) rst_n low mid-SEND (byte 20 of 58) -> all outputs reset within the same cycle, FIFO empty, aux=1.

Source files
------------

// File: rtl/rf_wless_packet_scheduler_pkg.sv
// Shared definitions for the wireless packet scheduler: scheduler states and framing constants.
package rf_wless_packet_scheduler_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int HDR_LEN        = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_HDR     = 3'd2,
    ST_SEND    = 3'd3,
    ST_GAP     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rf_wless_packet_scheduler_sync_fifo.sv
// Payload buffer for the packet scheduler: single-clock FIFO with occupancy count and full/empty flags.
module rf_wless_packet_scheduler_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_wless_packet_scheduler.sv
// Buffers MCU UART bytes, cuts them into air packets (threshold or idle timeout) and streams them to the
// node UART, optionally prefixing a 3-byte fixed-address header. Handshake: rx_use_mcu/tx_use_node are
// single-cycle pulses, at most one every two cycles; a push is only issued while tx_flag_node is low.
module rf_wless_packet_scheduler
  import rf_wless_packet_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH      = 64,
  parameter int START_THRESHOLD = 58,
  parameter int MAX_PACKET      = 58,
  parameter int IDLE_TIMEOUT    = 5000,
  parameter int GAP_CYCLES      = 16
) (
  input  logic                        internal_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        fixed_mode,
  input  logic                        rx_flag_mcu,
  input  logic [DATA_WIDTH-1:0]       data_from_uart_mcu,
  output logic                        rx_use_mcu,
  input  logic                        tx_flag_node,
  output logic                        tx_use_node,
  output logic [DATA_WIDTH-1:0]       data_to_uart_node,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic                        packet_start,
  output logic                        aux,
  output logic [2:0]                  state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int LW = $clog2(MAX_PACKET + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] THRESH_C   = CW'(START_THRESHOLD);
  localparam logic [CW-1:0] MAXP_C     = CW'(MAX_PACKET);
  localparam logic [TW-1:0] TIMEOUT_C  = TW'(IDLE_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST_C = GW'(GAP_CYCLES - 1);

  sched_state_t          state;
  logic                  fixed_q;
  logic [1:0]            hdr_cnt;
  logic [1:0]            hdr_idx;
  logic [DATA_WIDTH-1:0] addr_hi;
  logic [DATA_WIDTH-1:0] addr_lo;
  logic [DATA_WIDTH-1:0] chan;
  logic [TW-1:0]         idle_timer;
  logic [LW-1:0]         pkt_left;
  logic [GW-1:0]         gap_cnt;
  logic                  first_pending;

  logic                  accept;
  logic                  fixed_eff;
  logic                  to_hdr;
  logic                  to_fifo;
  logic                  fifo_wr;
  logic                  drop;
  logic                  push_ok;
  logic                  pop;
  logic                  hdr_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         pkt_len_next;
  logic [DATA_WIDTH-1:0] hdr_byte;

  assign accept       = rx_flag_mcu & enable & ~rx_use_mcu;
  // fixed_mode is only honoured at the start of a burst; afterwards the latched copy rules.
  assign fixed_eff    = (state == ST_IDLE) ? fixed_mode : fixed_q;
  assign to_hdr       = accept & fixed_eff & (hdr_cnt != 2'(HDR_LEN));
  assign to_fifo      = accept & ~to_hdr;
  assign fifo_wr      = to_fifo & ~fifo_full;
  assign drop         = to_fifo & fifo_full;
  assign push_ok      = ~tx_flag_node & ~tx_use_node;
  assign pop          = push_ok & (state == ST_SEND) & ~fifo_empty;
  assign hdr_push     = push_ok & (state == ST_HDR);
  assign pkt_len_next = (fifo_count > MAXP_C) ? MAXP_C : fifo_count;
  assign fill_level   = fifo_count;
  assign state_dbg    = state;

  always_comb begin
    hdr_byte = chan;
    case (hdr_idx)
      2'd0:    hdr_byte = addr_hi;
      2'd1:    hdr_byte = addr_lo;
      default: hdr_byte = chan;
    endcase
  end

  rf_wless_packet_scheduler_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (internal_clk),
    .rst_n (rst_n),
    .wr_en (fifo_wr),
    .din   (data_from_uart_mcu),
    .rd_en (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      fixed_q           <= 1'b0;
      hdr_cnt           <= '0;
      hdr_idx           <= '0;
      addr_hi           <= '0;
      addr_lo           <= '0;
      chan              <= '0;
      idle_timer        <= '0;
      pkt_left          <= '0;
      gap_cnt           <= '0;
      first_pending     <= 1'b0;
      rx_use_mcu        <= 1'b0;
      tx_use_node       <= 1'b0;
      data_to_uart_node <= '0;
      overflow          <= 1'b0;
      packet_start      <= 1'b0;
      aux               <= 1'b1;
    end else begin
      rx_use_mcu   <= accept;
      tx_use_node  <= 1'b0;
      packet_start <= 1'b0;

      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      if (to_hdr) begin
        case (hdr_cnt)
          2'd0:    addr_hi <= data_from_uart_mcu;
          2'd1:    addr_lo <= data_from_uart_mcu;
          default: chan    <= data_from_uart_mcu;
        endcase
        hdr_cnt <= hdr_cnt + 2'd1;
      end

      if (hdr_push | pop) begin
        tx_use_node       <= 1'b1;
        data_to_uart_node <= hdr_push ? hdr_byte : fifo_dout;
        packet_start      <= first_pending;
        first_pending     <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_COLLECT;
            fixed_q    <= fixed_mode;
            aux        <= 1'b0;
            idle_timer <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept)                       idle_timer <= '0;
          else if (idle_timer != TIMEOUT_C) idle_timer <= idle_timer + 1'b1;
          if ((fifo_count >= THRESH_C) ||
              ((fifo_count != '0) && (idle_timer == TIMEOUT_C))) begin
            pkt_left      <= LW'(pkt_len_next);
            first_pending <= 1'b1;
            hdr_idx       <= '0;
            state         <= fixed_q ? ST_HDR : ST_SEND;
          end
        end
        ST_HDR: begin
          if (hdr_push) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'(HDR_LEN - 1)) state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop) begin
            pkt_left <= pkt_left - 1'b1;
            if (pkt_left == LW'(1)) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST_C) begin
            idle_timer <= '0;
            // A byte landing on this very edge keeps the burst alive instead of restarting it.
            if ((fifo_count != '0) || accept) begin
              state <= ST_COLLECT;
            end else begin
              state   <= ST_IDLE;
              hdr_cnt <= '0;
              aux     <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wless_packet_scheduler.sv
// Self-checking bench for rf_wless_packet_scheduler: byte-stream scoreboard fed by a packet-level model.
module tb_rf_wless_packet_scheduler;
  import rf_wless_packet_scheduler_pkg::*;

  localparam int DW      = 8;
  localparam int DEPTH   = 64;
  localparam int THRESH  = 58;
  localparam int MAXP    = 58;
  localparam int TIMEOUT = 5000;
  localparam int GAP     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                      enable = 1'b0;
  logic                      fixed_mode = 1'b0;
  logic                      rx_flag_mcu = 1'b0;
  logic [DW-1:0]             data_from_uart_mcu = '0;
  logic                      rx_use_mcu;
  logic                      tx_flag_node = 1'b0;
  logic                      tx_use_node;
  logic [DW-1:0]             data_to_uart_node;
  logic [$clog2(DEPTH):0]    fill_level;
  logic                      overflow;
  logic                      overflow_clr = 1'b0;
  logic                      packet_start;
  logic                      aux;
  logic [2:0]                state_dbg;

  rf_wless_packet_scheduler #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .START_THRESHOLD (THRESH),
    .MAX_PACKET (MAXP), .IDLE_TIMEOUT (TIMEOUT), .GAP_CYCLES (GAP)
  ) dut (
    .internal_clk       (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .fixed_mode         (fixed_mode),
    .rx_flag_mcu        (rx_flag_mcu),
    .data_from_uart_mcu (data_from_uart_mcu),
    .rx_use_mcu         (rx_use_mcu),
    .tx_flag_node       (tx_flag_node),
    .tx_use_node        (tx_use_node),
    .data_to_uart_node  (data_to_uart_node),
    .fill_level         (fill_level),
    .overflow           (overflow),
    .overflow_clr       (overflow_clr),
    .packet_start       (packet_start),
    .aux                (aux),
    .state_dbg          (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_start_q[$];
  int push_cnt = 0;
  int start_cnt = 0;
  int extra_pushes = 0;
  logic prev_use = 1'b0;
  logic flag_at_edge = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) flag_at_edge <= tx_flag_node;

  always @(negedge clk) begin
    if (rst_n && tx_use_node) begin
      push_cnt++;
      if (packet_start) start_cnt++;
      check("push_spacing", 32'(prev_use), 0);
      check("push_while_tx_full", 32'(flag_at_edge), 0);
      if (exp_q.size() == 0) begin
        extra_pushes++;
      end else begin
        check("push_data", 32'(data_to_uart_node), 32'(exp_q.pop_front()));
        check("packet_start", 32'(packet_start), 32'(exp_start_q.pop_front()));
      end
    end
    prev_use = tx_use_node;
  end

  // ---------------- reference model ----------------
  // Payload leaves in arrival order, cut into packets of at most MAXP bytes; fixed mode adds the header.
  task automatic model_packets(input logic [DW-1:0] pl[$], input bit fixed,
                               input logic [DW-1:0] h0, input logic [DW-1:0] h1, input logic [DW-1:0] h2);
    int idx;
    int len;
    idx = 0;
    while (idx < pl.size()) begin
      len = (pl.size() - idx > MAXP) ? MAXP : pl.size() - idx;
      if (fixed) begin
        exp_q.push_back(h0); exp_start_q.push_back(1'b1);
        exp_q.push_back(h1); exp_start_q.push_back(1'b0);
        exp_q.push_back(h2); exp_start_q.push_back(1'b0);
      end
      for (int k = 0; k < len; k++) begin
        exp_q.push_back(pl[idx+k]);
        exp_start_q.push_back(!fixed && k == 0);
      end
      idx += len;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [DW-1:0] b);
    bit ok;
    int waitc;
    ok = 1'b0;
    waitc = 0;
    data_from_uart_mcu = b;
    rx_flag_mcu = 1'b1;
    while (!ok && waitc < 1000) begin
      @(negedge clk);
      waitc++;
      if (rx_use_mcu) ok = 1'b1;
    end
    rx_flag_mcu = 1'b0;
    check("rx_accepted", 32'(ok), 1);
  endtask

  task automatic send_list(input logic [DW-1:0] pl[$], input int max_gap);
    for (int i = 0; i < pl.size(); i++) begin
      send_byte(pl[i]);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c;
    c = 0;
    while (!(aux && state_dbg == ST_IDLE) && c < budget) begin
      @(negedge clk);
      c++;
    end
    #1;
    check(tag, 32'(aux && state_dbg == ST_IDLE), 1);
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  logic [DW-1:0] pl[$];
  logic [DW-1:0] kept[$];
  int base_push, base_start, cyc, rx_pulses;
  bit done;

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_aux", 32'(aux), 1);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_tx_use", 32'(tx_use_node), 0);
    check("rst_rx_use", 32'(rx_use_mcu), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // enable low: nothing accepted
    rx_flag_mcu = 1'b1;
    rx_pulses = 0;
    repeat (10) begin @(negedge clk); if (rx_use_mcu) rx_pulses++; end
    rx_flag_mcu = 1'b0;
    check("disabled_no_accept", 32'(rx_pulses), 0);
    check("disabled_aux", 32'(aux), 1);
    enable = 1'b1;

    // 1) transparent, 58 ascending bytes
    pl.delete();
    for (int i = 0; i < 58; i++) pl.push_back(DW'(i));
    model_packets(pl, 0, 0, 0, 0);
    base_push = push_cnt; base_start = start_cnt;
    send_list(pl, 0);
    wait_idle(2000, "t1_idle");
    check("t1_pushes", 32'(push_cnt - base_push), 58);
    check("t1_starts", 32'(start_cnt - base_start), 1);

    // 2) 5 bytes then silence: timeout flush
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(DW'($urandom));
    model_packets(pl, 0, 0, 0, 0);
    base_push = push_cnt;
    send_list(pl, 0);
    cyc = 0;
    while (state_dbg == ST_COLLECT && cyc < TIMEOUT + 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t2_flush_latency", 32'(cyc >= TIMEOUT - 1 && cyc <= TIMEOUT + 2), 1);
    wait_idle(500, "t2_idle");
    check("t2_pushes", 32'(push_cnt - base_push), 5);

    // 3) fixed mode: header then 100 payload bytes -> 58 + 42
    fixed_mode = 1'b1;
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(DW'($urandom));
    model_packets(pl, 1, 8'h12, 8'h34, 8'h07);
    base_push = push_cnt; base_start = start_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h07);
    send_list(pl, 2);
    wait_idle(TIMEOUT + 3000, "t3_idle");
    fixed_mode = 1'b0;
    check("t3_pushes", 32'(push_cnt - base_push), 106);
    check("t3_starts", 32'(start_cnt - base_start), 2);

    // 4) tx_flag_node held high for 200 cycles mid-SEND
    pl.delete();
    for (int i = 0; i < 58; i++) pl.push_back(DW'($urandom));
    model_packets(pl, 0, 0, 0, 0);
    base_push = push_cnt;
    send_list(pl, 0);
    cyc = 0;
    while (push_cnt < base_push + 10 && cyc < 1000) begin @(negedge clk); #1; cyc++; end
    check("t4_reached_mid", 32'(push_cnt - base_push), 10);
    tx_flag_node = 1'b1;
    base_start = push_cnt;
    repeat (200) begin @(negedge clk); #1; end
    check("t4_stall_no_push", 32'(push_cnt - base_start), 0);
    tx_flag_node = 1'b0;
    wait_idle(1000, "t4_idle");
    check("t4_pushes", 32'(push_cnt - base_push), 58);

    // 5) overflow: fill to DEPTH with node UART blocked, then 3 more
    tx_flag_node = 1'b1;
    kept.delete();
    for (int i = 0; i < DEPTH; i++) kept.push_back(DW'($urandom));
    model_packets(kept, 0, 0, 0, 0);
    send_list(kept, 1);
    #1;
    check("t5_fill_full", 32'(fill_level), DEPTH);
    check("t5_no_overflow_yet", 32'(overflow), 0);
    rx_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(DW'($urandom));
      rx_pulses++;
      @(negedge clk);
    end
    check("t5_rx_pulses", 32'(rx_pulses), 3);
    check("t5_overflow_set", 32'(overflow), 1);
    check("t5_fill_held", 32'(fill_level), DEPTH);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("t5_overflow_clr", 32'(overflow), 0);
    base_push = push_cnt;
    tx_flag_node = 1'b0;
    wait_idle(TIMEOUT + 2000, "t5_idle");
    check("t5_pushes", 32'(push_cnt - base_push), DEPTH);

    // 6) reset mid-SEND at byte 20
    pl.delete();
    for (int i = 0; i < 58; i++) pl.push_back(DW'($urandom));
    model_packets(pl, 0, 0, 0, 0);
    base_push = push_cnt;
    send_list(pl, 0);
    cyc = 0;
    while (push_cnt < base_push + 20 && cyc < 1000) begin @(negedge clk); #1; cyc++; end
    check("t6_reached_20", 32'(push_cnt - base_push), 20);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_tx_use", 32'(tx_use_node), 0);
    check("t6_rst_fill", 32'(fill_level), 0);
    check("t6_rst_aux", 32'(aux), 1);
    check("t6_rst_start", 32'(packet_start), 0);
    check("t6_rst_data", 32'(data_to_uart_node), 0);
    check("t6_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.delete();
    exp_start_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_post_fill", 32'(fill_level), 0);
    check("t6_post_aux", 32'(aux), 1);

    // random short bursts with a randomly stalling node UART
    for (int r = 0; r < 2; r++) begin
      pl.delete();
      for (int i = 0; i < $urandom_range(1, THRESH - 1); i++) pl.push_back(DW'($urandom));
      model_packets(pl, 0, 0, 0, 0);
      base_push = push_cnt;
      done = 1'b0;
      fork
        begin
          send_list(pl, 3);
          wait_idle(TIMEOUT + 2000, "rand_idle");
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            tx_flag_node = ($urandom_range(0, 3) == 0);
          end
          tx_flag_node = 1'b0;
        end
      join
      check("rand_pushes", 32'(push_cnt - base_push), 32'(pl.size()));
    end

    check("extra_pushes", 32'(extra_pushes), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
